// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave: header word sets a start address, following data words
// are written to auto-incrementing addresses through a one-cycle strobe port.
module spi_frame_receiver #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13,
  parameter int WORDS      = 1305
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  input  logic                  spi_cs_n,
  output logic [DATA_WIDTH-1:0] spi_data,
  output logic [ADDR_WIDTH-1:0] spi_address,
  output logic                  spi_write_strobe,
  output logic                  frame_done,
  output logic                  overrun,
  output logic                  busy
);

  localparam int                    CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIM = ADDR_WIDTH'(WORDS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} state_t;

  state_t r_state, w_state_nxt;

  logic r_sck_s1, r_sck_s2, r_sck_s3;
  logic r_cs_s1, r_cs_s2, r_cs_s3;
  logic r_mosi_s1, r_mosi_s2;
  logic [1:0] r_sync_vld;
  logic r_cs_armed;

  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_strobe, r_frame_done, r_overrun, r_busy;

  logic                  w_sck_rise, w_cs_fall, w_cs_rise;
  logic                  w_bit_take, w_last;
  logic [DATA_WIDTH-1:0] w_word;

  // Synchronisers plus edge-detect stage; cs_n resets high and sck low.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sck_s1   <= 1'b0;
      r_sck_s2   <= 1'b0;
      r_sck_s3   <= 1'b0;
      r_cs_s1    <= 1'b1;
      r_cs_s2    <= 1'b1;
      r_cs_s3    <= 1'b1;
      r_mosi_s1  <= 1'b0;
      r_mosi_s2  <= 1'b0;
      r_sync_vld <= 2'b00;
      r_cs_armed <= 1'b0;
    end else begin
      r_sck_s1   <= spi_sck;
      r_sck_s2   <= r_sck_s1;
      r_sck_s3   <= r_sck_s2;
      r_cs_s1    <= spi_cs_n;
      r_cs_s2    <= r_cs_s1;
      r_cs_s3    <= r_cs_s2;
      r_mosi_s1  <= spi_mosi;
      r_mosi_s2  <= r_mosi_s1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      // A falling CS only counts once a genuinely high CS has been observed,
      // so CS held low across reset cannot open a transaction.
      if (r_sync_vld[1] && r_cs_s2)
        r_cs_armed <= 1'b1;
    end
  end

  assign w_sck_rise = r_sck_s2 & ~r_sck_s3;
  assign w_cs_fall  = r_cs_armed & r_cs_s3 & ~r_cs_s2;
  assign w_cs_rise  = r_cs_s2 & ~r_cs_s3;

  // cs_rise wins over a coincident sck_rise, discarding that bit.
  assign w_bit_take = (r_state != S_IDLE) & w_sck_rise & ~w_cs_rise;
  assign w_last     = w_bit_take & (r_bit_cnt == LAST_BIT);
  assign w_word     = {r_shift[DATA_WIDTH-2:0], r_mosi_s2};

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_cs_fall) w_state_nxt = S_HEADER;
      S_HEADER: if (w_cs_rise) w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_DATA;
      S_DATA:   if (w_cs_rise) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Shift/count datapath, address tracking, strobe and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_wr_addr    <= '0;
      r_data       <= '0;
      r_addr       <= '0;
      r_strobe     <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_strobe     <= 1'b0;
      r_frame_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_cs_fall) begin
          r_bit_cnt <= '0;
          r_shift   <= '0;
          r_overrun <= 1'b0;
          r_busy    <= 1'b1;
        end
      end else if (w_cs_rise) begin
        r_bit_cnt    <= '0;
        r_busy       <= 1'b0;
        r_frame_done <= 1'b1;
      end else if (w_bit_take) begin
        r_shift   <= w_word;
        r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
        if (w_last && r_state == S_HEADER) begin
          r_wr_addr <= w_word[ADDR_WIDTH-1:0];
          if (w_word[ADDR_WIDTH-1:0] >= ADDR_LIM)
            r_overrun <= 1'b1;
        end
        if (w_last && r_state == S_DATA) begin
          if (r_wr_addr < ADDR_LIM) begin
            r_data   <= w_word;
            r_addr   <= r_wr_addr;
            r_strobe <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
          // Saturate rather than wrap so a long burst never rewrites address 0.
          if (r_wr_addr != ADDR_MAX)
            r_wr_addr <= r_wr_addr + 1'b1;
        end
      end
    end
  end

  assign spi_data         = r_data;
  assign spi_address      = r_addr;
  assign spi_write_strobe = r_strobe;
  assign frame_done       = r_frame_done;
  assign overrun          = r_overrun;
  assign busy             = r_busy;

endmodule
